multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath enables (PC, IR, register file, ALU operand select, memory port) over several cycles instead of one. It owns a single shared instruction/data memory port with a ready handshake and a wait-state watchdog, counts retired instructions, and traps on illegal opcodes or bus timeouts. It sits between the IR/opcode field and the datapath, replacing the single-cycle decode-only control path.

## Interface
- TIMEOUT, 16: number of consecutive unacknowledged memory-wait cycles before trapping; 0 disables the watchdog.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- opcode  in  7  opcode field of the IR; valid from DECODE until the next fetch completes.
- take_branch  in  1  branch condition result from the ALU; sampled in EXEC.
- mem_ready  in  1  memory acknowledge; meaningful only while mem_req=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualifies mem_req.
- iord  out  1  address select: 0=PC, 1=ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  PC source: 0=PC+4, 1=branch target (held old_pc+imm).
- alusrc  out  1  ALU operand B: 0=rs2, 1=immediate.
- memtoreg  out  1  writeback source: 0=ALU, 1=memory data.
- regwrite  out  1  register file write enable.
- instret  out  32  retired instruction count.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00=none, 01=illegal opcode, 10=bus timeout.

## Operation
- Supported opcodes are R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011 and BRANCH=1100011. Every other opcode is illegal.
- FETCH
  - Asserts mem_req=1, iord=0, mem_we=0.
  - When mem_ready=1, pulses ir_write=1 and pc_write=1 (pc_src=0) in that same cycle, then moves to DECODE.
  - Otherwise it holds in FETCH.
- DECODE
  - Legal opcode: moves to EXEC.
  - Illegal opcode: moves to TRAP with cause 01.
  - No datapath enables are asserted.
- EXEC
  - alusrc=1 for I-ALU, LOAD and STORE; 0 for R and BRANCH.
  - R and I-ALU go to WB; LOAD and STORE go to MEM.
  - BRANCH
    - take_branch=1: pc_write=1 with pc_src=1.
    - Either way it retires and goes to FETCH.
- MEM
  - Asserts mem_req=1, iord=1, alusrc=1; mem_we=1 for STORE only.
  - On mem_ready=1, LOAD goes to WB; STORE retires and goes to FETCH.
- WB
  - Asserts regwrite=1, with memtoreg=1 for LOAD and 0 otherwise.
  - Retires and goes to FETCH.
- TRAP
  - All enables are 0, trap=1, and trap_cause holds its value.
  - Leaves TRAP only on rst.
- Retire means instret increments by 1 (modulo 2^32, wraps silently) in the cycle of the final state.
- Outputs are a combinational decode of the state plus opcode. ir_write, pc_write and the FETCH/MEM exits are additionally qualified by mem_ready.

## Timing
- Reset
  - While rst=1, all outputs are 0, instret=0, trap_cause=00, and state becomes FETCH.
  - mem_req rises in the first cycle after rst falls.
- Latency with zero wait states:
  - BRANCH: 3 cycles.
  - R, I-ALU, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- Handshake
  - A transfer completes in the cycle where mem_req=1 and mem_ready=1.
  - mem_req, iord and mem_we stay stable until then.
  - mem_ready while mem_req=0 is ignored.
- Watchdog
  - The counter clears on entry to FETCH or MEM and increments each cycle with mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT, the next state is TRAP with cause 10.
  - If mem_ready=1 arrives in that same cycle, the transfer wins and no trap is taken.
- Reset mid-operation: the instruction in flight is aborted without retiring, mem_req drops immediately, and the outstanding request is abandoned.
- take_branch is sampled only in EXEC for BRANCH.
- opcode is assumed stable from DECODE through the final state; its value in FETCH is don't-care.

## Structure
- Shared include riscv_defs.vh holds:
  - opcode localparams (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH);
  - state encodings S_FETCH..S_TRAP (3 bits);
  - trap cause codes.
- One sub-module, mem_wait_timer: parameterised TIMEOUT, with clear, count-enable and expired outputs. Everything else stays in multicycle_ctrl.

## Test plan
- Reset, then an ADD (0110011) with mem_ready always 1:
  - states go F,D,E,W;
  - regwrite=1 only in cycle 4;
  - instret=1 after 4 cycles.
- LOAD with 2 FETCH wait cycles and 1 MEM wait cycle:
  - completes in 8 cycles;
  - memtoreg=regwrite=1 in WB;
  - iord=1 only in MEM.
- BRANCH run twice:
  - take_branch=1: pc_write=1 with pc_src=1 in EXEC, 3 cycles total.
  - take_branch=0: no PC update in EXEC.
- Opcode 1111111 in DECODE: moves to TRAP with trap=1 and cause 01; instret is unchanged; the block stays in TRAP until rst.
- mem_ready held 0 in MEM:
  - trap with cause 10 after 16 wait cycles;
  - repeat with mem_ready=1 on wait cycle 16: no trap.
- rst asserted during MEM of a STORE: mem_req and mem_we drop in the same cycle, instret=0, and FETCH is re-entered.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// opcode values, state encodings, trap cause codes and an opcode legality helper.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  // True for the five opcode classes this core executes.
  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-state watchdog for the shared memory port. Counts consecutive
// unacknowledged request cycles and flags the cycle in which the count
// would reach TIMEOUT. TIMEOUT = 0 disables the watchdog.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] count;

  // Wait counter: restarts whenever the controller changes state, advances on each stalled cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_en && (TIMEOUT != 0)) begin
      count <= count + W'(1);
    end
  end

  // The stalled cycle that completes TIMEOUT waits is the expiring one, so a
  // ready arriving in that cycle (count_en low) still wins over the trap.
  assign expired = (TIMEOUT != 0) && count_en && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables, arbitrates the
// shared memory port, counts retired instructions and traps on illegal
// opcodes or memory timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        take_branch,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alusrc,
  output logic        memtoreg,
  output logic        regwrite,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t      state, state_n;
  cause_t      cause_q, cause_n;
  logic [31:0] instret_q;
  logic        retire;

  logic mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
  logic pc_src_c, alusrc_c, memtoreg_c, regwrite_c;

  logic wd_clear, wd_en, wd_expired;

  logic is_load, is_store, is_branch, is_ialu;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_ialu   = (opcode == OP_IALU);

  // Watchdog counts only while the port is requested and unacknowledged;
  // any state change restarts it so each FETCH/MEM visit starts from zero.
  assign wd_en    = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign wd_clear = (state_n != state);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_en),
    .expired  (wd_expired)
  );

  // State and trap-cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
    end
  end

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state and datapath-enable decode from the current state and opcode.
  always_comb begin
    state_n    = state;
    cause_n    = cause_q;
    retire     = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    pc_src_c   = 1'b0;
    alusrc_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_n    = S_DECODE;
        end else if (wd_expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_n = S_EXEC;
        end else begin
          state_n = S_TRAP;
          cause_n = CAUSE_ILLEGAL;
        end
      end

      S_EXEC: begin
        alusrc_c = is_ialu || is_load || is_store;
        if (is_branch) begin
          pc_write_c = take_branch;
          pc_src_c   = take_branch;
          retire     = 1'b1;
          state_n    = S_FETCH;
        end else if (is_load || is_store) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        alusrc_c  = 1'b1;
        mem_we_c  = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_n = S_WB;
          end else begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end
        end else if (wd_expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        regwrite_c = 1'b1;
        memtoreg_c = is_load;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end

      S_TRAP: begin
        state_n = S_TRAP;
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // Reset forces every output low at once so an in-flight request is dropped
  // in the same cycle rather than one clock later.
  assign mem_req    = mem_req_c  && !rst;
  assign mem_we     = mem_we_c   && !rst;
  assign iord       = iord_c     && !rst;
  assign ir_write   = ir_write_c && !rst;
  assign pc_write   = pc_write_c && !rst;
  assign pc_src     = pc_src_c   && !rst;
  assign alusrc     = alusrc_c   && !rst;
  assign memtoreg   = memtoreg_c && !rst;
  assign regwrite   = regwrite_c && !rst;
  assign instret    = rst ? 32'd0 : instret_q;
  assign trap       = (state == S_TRAP) && !rst;
  assign trap_cause = rst ? 2'b00 : cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table,
// hand-written trap/watchdog/reset sequences and randomized instruction
// streams checked against an instruction-level expected-trace model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        take_branch;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic        alusrc, memtoreg, regwrite, trap;
  logic [31:0] instret;
  logic [1:0]  trap_cause;
  logic [8:0]  ctl;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_instret;

  typedef struct {
    string      ph;
    logic       rdy;
    logic       tkb;
    logic [6:0] op;
    logic [8:0] ctl;
    logic       retire;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    logic       tkb;
    int         cycles;
  } vec_t;

  cyc_t expq[$];
  vec_t vecs[9];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc, memtoreg, regwrite};

  multicycle_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .take_branch (take_branch),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alusrc      (alusrc),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .instret     (instret),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  function automatic logic [8:0] ctlOf(input logic req, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic als, input logic m2r, input logic rw);
    return {req, we, io, irw, pcw, pcs, als, m2r, rw};
  endfunction

  function automatic logic [6:0] randomOp();
    case ($urandom_range(0, 4))
      0:       return OP_R;
      1:       return OP_IALU;
      2:       return OP_LOAD;
      3:       return OP_STORE;
      default: return OP_BRANCH;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge and let the combinational outputs settle.
  task automatic applyStimulus(input logic rdy, input logic [6:0] op, input logic tkb);
    mem_ready   = rdy;
    opcode      = op;
    take_branch = tkb;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCyc(input string ph, input logic rdy, input logic tkb,
                         input logic [6:0] op, input logic [8:0] c, input logic ret);
    cyc_t e;
    e.ph = ph; e.rdy = rdy; e.tkb = tkb; e.op = op; e.ctl = c; e.retire = ret;
    expq.push_back(e);
  endtask

  // Expected per-cycle trace of one instruction, built from its phase list:
  // fetch (with waits), decode, execute, optional memory (with waits), optional writeback.
  task automatic buildInstr(input logic [6:0] op, input int fw, input int mw, input logic tkb);
    logic ld, st, br, imm;
    ld  = (op == OP_LOAD);
    st  = (op == OP_STORE);
    br  = (op == OP_BRANCH);
    imm = (op == OP_IALU) || ld || st;
    for (int i = 0; i < fw; i++)
      pushCyc("F", 1'b0, 1'($urandom), 7'($urandom), ctlOf(1,0,0,0,0,0,0,0,0), 1'b0);
    pushCyc("F", 1'b1, 1'($urandom), 7'($urandom), ctlOf(1,0,0,1,1,0,0,0,0), 1'b0);
    pushCyc("D", 1'($urandom), 1'($urandom), op, ctlOf(0,0,0,0,0,0,0,0,0), 1'b0);
    pushCyc("E", 1'($urandom), br ? tkb : 1'($urandom), op,
            ctlOf(0,0,0,0,br && tkb,br && tkb,imm,0,0), br);
    if (ld || st) begin
      for (int i = 0; i < mw; i++)
        pushCyc("M", 1'b0, 1'($urandom), op, ctlOf(1,st,1,0,0,0,1,0,0), 1'b0);
      pushCyc("M", 1'b1, 1'($urandom), op, ctlOf(1,st,1,0,0,0,1,0,0), st);
    end
    if (!br && !st)
      pushCyc("W", 1'($urandom), 1'($urandom), op, ctlOf(0,0,0,0,0,0,0,ld,1), 1'b1);
  endtask

  // Run one instruction from FETCH, checking every cycle; reports the cycle
  // after which the DUT's instret first changed (-1 if it never did).
  task automatic runInstr(input logic [6:0] op, input int fw, input int mw, input logic tkb,
                          output int cycles);
    cyc_t        c;
    logic [31:0] start;
    int          n;
    expq.delete();
    buildInstr(op, fw, mw, tkb);
    start  = model_instret;
    cycles = -1;
    n      = 0;
    while (expq.size() > 0) begin
      c = expq.pop_front();
      applyStimulus(c.rdy, c.op, c.tkb);
      checkOutput({c.ph, "-ctl"}, 32'(ctl), 32'(c.ctl));
      checkOutput({c.ph, "-instret"}, instret, model_instret);
      checkOutput({c.ph, "-trap"}, 32'({trap, trap_cause}), 32'd0);
      nextCycle();
      n++;
      if (c.retire) model_instret++;
      if (cycles < 0 && instret != start) cycles = n;
    end
  endtask

  // Hold reset for one cycle, checking that every output is low, then release into FETCH.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b1, randomOp(), 1'b1);
    checkOutput("rst-ctl", 32'(ctl), 32'd0);
    checkOutput("rst-instret", instret, 32'd0);
    checkOutput("rst-trap", 32'({trap, trap_cause}), 32'd0);
    nextCycle();
    rst = 1'b0;
    model_instret = 32'd0;
  endtask

  // Walk a LOAD or STORE through fetch, decode and execute with no wait states.
  task automatic enterMem(input logic [6:0] op);
    applyStimulus(1'b1, 7'($urandom), 1'b0);
    nextCycle();
    applyStimulus(1'b0, op, 1'b0);
    nextCycle();
    applyStimulus(1'b0, op, 1'b0);
    checkOutput("pre-mem-exec", 32'(ctl), 32'(ctlOf(0,0,0,0,0,0,1,0,0)));
    nextCycle();
  endtask

  initial begin
    int cyc;

    vecs[0] = '{op: OP_R,      fw: 0, mw: 0, tkb: 1'b0, cycles: 4};
    vecs[1] = '{op: OP_IALU,   fw: 0, mw: 0, tkb: 1'b1, cycles: 4};
    vecs[2] = '{op: OP_LOAD,   fw: 0, mw: 0, tkb: 1'b0, cycles: 5};
    vecs[3] = '{op: OP_STORE,  fw: 0, mw: 0, tkb: 1'b0, cycles: 4};
    vecs[4] = '{op: OP_BRANCH, fw: 0, mw: 0, tkb: 1'b1, cycles: 3};
    vecs[5] = '{op: OP_BRANCH, fw: 0, mw: 0, tkb: 1'b0, cycles: 3};
    vecs[6] = '{op: OP_LOAD,   fw: 2, mw: 1, tkb: 1'b0, cycles: 8};
    vecs[7] = '{op: OP_STORE,  fw: 1, mw: 2, tkb: 1'b1, cycles: 7};
    vecs[8] = '{op: OP_R,      fw: 3, mw: 0, tkb: 1'b1, cycles: 7};

    rst         = 1'b1;
    mem_ready   = 1'b1;
    opcode      = OP_STORE;
    take_branch = 1'b1;
    repeat (2) nextCycle();
    doReset();

    applyStimulus(1'b0, OP_R, 1'b0);
    checkOutput("first-fetch-req", 32'(ctl), 32'(ctlOf(1,0,0,0,0,0,0,0,0)));
    nextCycle();

    for (int i = 0; i < 9; i++) begin
      runInstr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].tkb, cyc);
      checkOutput($sformatf("vec%0d-cycles", i), 32'(cyc), 32'(vecs[i].cycles));
    end

    applyStimulus(1'b1, 7'($urandom), 1'b0);
    checkOutput("ill-fetch", 32'(ctl), 32'(ctlOf(1,0,0,1,1,0,0,0,0)));
    nextCycle();
    applyStimulus(1'b0, 7'h7F, 1'b0);
    checkOutput("ill-decode", 32'(ctl), 32'd0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'($urandom), (k < 2) ? 7'h7F : randomOp(), 1'($urandom));
      checkOutput("ill-trap", 32'({trap, trap_cause}), 32'b101);
      checkOutput("ill-ctl", 32'(ctl), 32'd0);
      checkOutput("ill-instret", instret, model_instret);
      nextCycle();
    end
    doReset();

    enterMem(OP_LOAD);
    for (int w = 1; w <= TIMEOUT; w++) begin
      applyStimulus(1'b0, OP_LOAD, 1'b0);
      checkOutput($sformatf("wd-wait%0d-ctl", w), 32'(ctl), 32'(ctlOf(1,0,1,0,0,0,1,0,0)));
      checkOutput($sformatf("wd-wait%0d-trap", w), 32'(trap), 32'd0);
      nextCycle();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, OP_LOAD, 1'b0);
      checkOutput("wd-trap", 32'({trap, trap_cause}), 32'b110);
      checkOutput("wd-trap-ctl", 32'(ctl), 32'd0);
      checkOutput("wd-trap-instret", instret, 32'd0);
      nextCycle();
    end
    doReset();

    enterMem(OP_LOAD);
    for (int w = 1; w < TIMEOUT; w++) begin
      applyStimulus(1'b0, OP_LOAD, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, OP_LOAD, 1'b0);
    checkOutput("wd-late-ready-ctl", 32'(ctl), 32'(ctlOf(1,0,1,0,0,0,1,0,0)));
    nextCycle();
    applyStimulus(1'b0, OP_LOAD, 1'b0);
    checkOutput("wd-late-wb-ctl", 32'(ctl), 32'(ctlOf(0,0,0,0,0,0,0,1,1)));
    checkOutput("wd-late-trap", 32'({trap, trap_cause}), 32'd0);
    nextCycle();
    model_instret++;
    checkOutput("wd-late-instret", instret, model_instret);

    for (int i = 0; i < 40; i++) begin
      runInstr(randomOp(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), cyc);
      checkOutput($sformatf("rand%0d-retired", i), 32'(cyc > 0), 32'd1);
    end

    enterMem(OP_STORE);
    applyStimulus(1'b0, OP_STORE, 1'b0);
    checkOutput("mid-rst-mem-ctl", 32'(ctl), 32'(ctlOf(1,1,1,0,0,0,1,0,0)));
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, OP_STORE, 1'b0);
    checkOutput("mid-rst-ctl", 32'(ctl), 32'd0);
    checkOutput("mid-rst-instret", instret, 32'd0);
    nextCycle();
    rst = 1'b0;
    model_instret = 32'd0;
    applyStimulus(1'b0, OP_R, 1'b0);
    checkOutput("mid-rst-refetch", 32'(ctl), 32'(ctlOf(1,0,0,0,0,0,0,0,0)));
    checkOutput("mid-rst-instret-after", instret, 32'd0);
    nextCycle();
    runInstr(OP_R, 0, 0, 1'b0, cyc);
    checkOutput("post-rst-cycles", 32'(cyc), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
